// File: rtl/sle_scan_loader_if.sv
// sle_scan_loader_if: bus bundle for the scan loader.
//   master : drives EN, SLn, D, start, SI; observes Q, SO, busy, done
//   slave  : the loader side (inverse directions)
interface sle_scan_loader_if #(parameter int WIDTH = 8);
  logic             EN;
  logic             SLn;
  logic [WIDTH-1:0] D;
  logic             start;
  logic             SI;
  logic [WIDTH-1:0] Q;
  logic             SO;
  logic             busy;
  logic             done;

  modport master (output EN, SLn, D, start, SI, input  Q, SO, busy, done);
  modport slave  (input  EN, SLn, D, start, SI, output Q, SO, busy, done);
endinterface

// File: rtl/sle_scan_loader.sv
// sle_scan_loader: parallel/serial register bank feeding a bank of SLE-style
// flops. In IDLE it parallel-loads D (SLn=1) or a replicated SD_VAL (SLn=0)
// when EN=1. A start in IDLE launches a stallable serial scan-load of exactly
// WIDTH bits (SI enters at Q[0], SO is Q[WIDTH-1]), ending in a one-cycle DONE.
// Ports:
//   CLk   : clock, rising edge
//   rst   : synchronous active-high reset
//   bus   : slave modport (EN, SLn, D, start, SI in; Q, SO, busy, done out)
module sle_scan_loader #(
  parameter int   WIDTH  = 8,
  parameter logic SD_VAL = 1'b0
) (
  input logic               CLk,
  input logic               rst,
  sle_scan_loader_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [CW-1:0]    w_cnt_inc;

  assign w_cnt_inc = r_cnt + CW'(1);

  always_ff @(posedge CLk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        // start wins over any load on the same edge
        if (bus.start) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
        end else if (bus.EN) begin
          w_q_nxt = bus.SLn ? bus.D : {WIDTH{SD_VAL}};
        end
      end
      S_SHIFT: begin
        // EN=0 stalls both Q and the counter
        if (bus.EN) begin
          w_q_nxt   = {r_q[WIDTH-2:0], bus.SI};
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == LAST) w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // flags decode registered state only
  assign bus.Q    = r_q;
  assign bus.SO   = r_q[WIDTH-1];
  assign bus.busy = (r_state == S_SHIFT);
  assign bus.done = (r_state == S_DONE);
endmodule

// File: tb/tb_sle_scan_loader.sv
module tb_sle_scan_loader;
  localparam int W = 8;

  logic         CLk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0, sln = 1'b0, start = 1'b0, si = 1'b0;
  logic [W-1:0] d = '0;

  int checks = 0;
  int failures = 0;

  sle_scan_loader_if #(.WIDTH(W)) ifa ();
  sle_scan_loader_if #(.WIDTH(W)) ifb ();

  // both DUTs see identical stimulus; they differ only in SD_VAL
  assign ifa.EN = en;    assign ifb.EN = en;
  assign ifa.SLn = sln;  assign ifb.SLn = sln;
  assign ifa.D = d;      assign ifb.D = d;
  assign ifa.start = start; assign ifb.start = start;
  assign ifa.SI = si;    assign ifb.SI = si;

  sle_scan_loader #(.WIDTH(W), .SD_VAL(1'b0)) dut_a (.CLk(CLk), .rst(rst), .bus(ifa));
  sle_scan_loader #(.WIDTH(W), .SD_VAL(1'b1)) dut_b (.CLk(CLk), .rst(rst), .bus(ifb));

  always #5 CLk = ~CLk;

  task automatic tick();
    @(posedge CLk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // clean-scan stream and hand-computed Q after each shift
  logic [W-1:0] si_stream;
  logic [W-1:0] qa_exp [8];
  logic [W-1:0] qb_exp [8];
  logic         so_exp [8];

  int d1, d2, npulse;

  initial begin
    si_stream = 8'b1011_0010;  // MSB first: 1,0,1,1,0,0,1,0
    qa_exp = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
    qb_exp = '{8'hFF, 8'hFE, 8'hFD, 8'hFB, 8'hF6, 8'hEC, 8'hD9, 8'hB2};
    so_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};  // SO before shift i

    // reset
    rst = 1'b1;
    tick(); tick();
    chk("rst_q", 32'(ifa.Q), 32'h00);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_done", 32'(ifa.done), 32'd0);
    chk("rst_so", 32'(ifa.SO), 32'd0);
    chk("rst_qb", 32'(ifb.Q), 32'h00);

    // parallel load and hold
    rst = 1'b0; en = 1'b1; sln = 1'b1; d = 8'hA5;
    tick();
    chk("pload_q", 32'(ifa.Q), 32'hA5);
    chk("pload_so", 32'(ifa.SO), 32'd1);
    en = 1'b0; d = 8'hFF;
    tick();
    chk("hold_q", 32'(ifa.Q), 32'hA5);

    // synchronous load value
    en = 1'b1; sln = 1'b0;
    tick();
    chk("sd0_q", 32'(ifa.Q), 32'h00);
    chk("sd1_q", 32'(ifb.Q), 32'hFF);
    chk("sd1_so", 32'(ifb.SO), 32'd1);

    // start with EN=1 on the same edge: Q holds, busy rises
    start = 1'b1; en = 1'b1; sln = 1'b1; d = 8'h5A;
    tick();
    chk("start_q", 32'(ifa.Q), 32'h00);
    chk("start_busy", 32'(ifa.busy), 32'd1);
    chk("start_qb", 32'(ifb.Q), 32'hFF);

    // clean scan
    start = 1'b0; en = 1'b1;
    for (int i = 0; i < W; i++) begin
      chk("scan_so_pre", 32'(ifa.SO), 32'(so_exp[i]));
      si = si_stream[W-1-i];
      tick();
      chk("scan_qa", 32'(ifa.Q), 32'(qa_exp[i]));
      chk("scan_qb", 32'(ifb.Q), 32'(qb_exp[i]));
      if (i < W-1) begin
        chk("scan_busy", 32'(ifa.busy), 32'd1);
        chk("scan_nodone", 32'(ifa.done), 32'd0);
      end
    end
    chk("scan_done", 32'(ifa.done), 32'd1);
    chk("scan_busy_off", 32'(ifa.busy), 32'd0);
    // DONE ignores inputs
    en = 1'b1; sln = 1'b1; d = 8'h00; start = 1'b0;
    tick();
    chk("done_hold_q", 32'(ifa.Q), 32'hB2);
    chk("idle_done", 32'(ifa.done), 32'd0);
    chk("idle_busy", 32'(ifa.busy), 32'd0);

    // stall: 3 cycles of EN=0 after the 4th shift
    en = 1'b1; sln = 1'b0;
    tick();
    chk("stall_pre_q", 32'(ifa.Q), 32'h00);
    en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == 4) begin
        en = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("stall_q", 32'(ifa.Q), 32'h0B);
          chk("stall_busy", 32'(ifa.busy), 32'd1);
          chk("stall_nodone", 32'(ifa.done), 32'd0);
        end
      end
      en = 1'b1;
      si = si_stream[W-1-i];
      tick();
      chk("stall_scan_q", 32'(ifa.Q), 32'(qa_exp[i]));
      if (i < W-1) chk("stall_nodone2", 32'(ifa.done), 32'd0);
    end
    chk("stall_done", 32'(ifa.done), 32'd1);
    en = 1'b0;
    tick();
    chk("stall_idle", 32'(ifa.done), 32'd0);

    // reset mid-shift
    en = 1'b1; sln = 1'b0;
    tick();
    en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; en = 1'b1; si = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_q5", 32'(ifa.Q), 32'h1F);
    rst = 1'b1; en = 1'b0;
    tick();
    chk("mid_rst_q", 32'(ifa.Q), 32'h00);
    chk("mid_rst_busy", 32'(ifa.busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_no_done", 32'(ifa.done), 32'd0);
      chk("mid_idle", 32'(ifa.busy), 32'd0);
    end
    start = 1'b1;
    tick();
    start = 1'b0; en = 1'b1; si = 1'b1;
    for (int i = 0; i < W-1; i++) tick();
    chk("restart_nodone", 32'(ifa.done), 32'd0);
    tick();
    chk("restart_done", 32'(ifa.done), 32'd1);
    chk("restart_q", 32'(ifa.Q), 32'hFF);
    en = 1'b0;
    tick();

    // back-to-back with start held; SLn/D toggle, must be ignored
    start = 1'b1; en = 1'b1; si = 1'b0; d = 8'hFF;
    d1 = -1; d2 = -1; npulse = 0;
    for (int t = 1; t <= 19; t++) begin
      sln = t[0];
      tick();
      if (ifa.done === 1'b1) begin
        npulse++;
        if (d1 < 0) d1 = t; else d2 = t;
      end
    end
    chk("b2b_first", 32'(d1), 32'd9);
    chk("b2b_second", 32'(d2), 32'd19);
    chk("b2b_pulses", 32'(npulse), 32'd2);
    chk("b2b_q", 32'(ifa.Q), 32'h00);
    start = 1'b0; en = 1'b0;
    tick();
    chk("b2b_idle", 32'(ifa.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
